// File: rtl/tx_clk_supervisor.sv
// rtl/tx_clk_supervisor.sv - TX PLL reset/lock supervisor with staggered channel reset release
module tx_clk_supervisor #(
    parameter int NUM_CH           = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int CH_STAGGER_CYC   = 8,
    parameter int CNT_W            = 8
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              lol_clr,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              clk_ok,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  lol_count,
    output logic [CNT_W-1:0]  retry_count,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [31:0]      RST_LAST     = 32'(PLL_RST_CYC - 1);
    localparam logic [31:0]      STABLE_LAST  = 32'(LOCK_STABLE_CYC - 1);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [31:0]      RUN_SLOT     = 32'((NUM_CH - 1) * CH_STAGGER_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t                 st;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_locked;
    logic [NUM_CH-1:0]      ch_en_q;
    logic [31:0]            rst_cnt;
    logic [31:0]            to_cnt;
    logic [31:0]            stable_cnt;
    logic [31:0]            slot_cnt;
    logic                   lol_evt;
    logic                   locked_ok;
    logic                   timeout_evt;

    assign state       = st;
    assign sync_locked = sync_q[SYNC_STAGES-1];

    // Stable qualification takes priority over a coincident timeout.
    assign lol_evt     = ((st == S_RELEASE) || (st == S_RUN)) && !sync_locked;
    assign locked_ok   = (st == S_WAIT_LOCK) && sync_locked && (stable_cnt == STABLE_LAST);
    assign timeout_evt = (st == S_WAIT_LOCK) && !locked_ok && (to_cnt == TIMEOUT_LAST);

    always_ff @(posedge refclk) begin
        if (rst) begin
            st          <= S_PLL_RST;
            sync_q      <= '0;
            ch_en_q     <= '0;
            rst_cnt     <= '0;
            to_cnt      <= '0;
            stable_cnt  <= '0;
            slot_cnt    <= '0;
            pll_rst     <= 1'b1;
            ch_rst      <= '1;
            clk_ok      <= 1'b0;
            lol_count   <= '0;
            retry_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            ch_en_q <= ch_en;

            // A clear in the same cycle as an event leaves exactly that one event counted.
            if (lol_clr)
                lol_count <= CNT_W'(lol_evt);
            else if (lol_evt && (lol_count != CNT_MAX))
                lol_count <= lol_count + 1'b1;

            if (lol_clr)
                retry_count <= CNT_W'(timeout_evt);
            else if (timeout_evt && (retry_count != CNT_MAX))
                retry_count <= retry_count + 1'b1;

            if (lol_clr)
                timeout_err <= timeout_evt;
            else if (timeout_evt)
                timeout_err <= 1'b1;

            if (lol_evt) begin
                st      <= S_PLL_RST;
                pll_rst <= 1'b1;
                ch_rst  <= '1;
                clk_ok  <= 1'b0;
                rst_cnt <= '0;
            end else begin
                case (st)
                    S_PLL_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            st         <= S_WAIT_LOCK;
                            pll_rst    <= 1'b0;
                            to_cnt     <= '0;
                            stable_cnt <= '0;
                        end else begin
                            rst_cnt <= rst_cnt + 32'd1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (locked_ok) begin
                            st       <= S_RELEASE;
                            slot_cnt <= '0;
                            if (ch_en[0])
                                ch_rst[0] <= 1'b0;
                        end else if (timeout_evt) begin
                            st      <= S_PLL_RST;
                            pll_rst <= 1'b1;
                            rst_cnt <= '0;
                        end else begin
                            to_cnt     <= to_cnt + 32'd1;
                            stable_cnt <= sync_locked ? stable_cnt + 32'd1 : '0;
                        end
                    end
                    S_RELEASE: begin
                        slot_cnt <= slot_cnt + 32'd1;
                        // Disabled channels still occupy their slot so the others keep their timing.
                        for (int i = 1; i < NUM_CH; i++) begin
                            if ((slot_cnt + 32'd1 == 32'(i * CH_STAGGER_CYC)) && ch_en[i])
                                ch_rst[i] <= 1'b0;
                        end
                        if (slot_cnt == RUN_SLOT) begin
                            st     <= S_RUN;
                            clk_ok <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_en[i] && !ch_en_q[i])
                                ch_rst[i] <= 1'b0;
                            else if (!ch_en[i] && ch_en_q[i])
                                ch_rst[i] <= 1'b1;
                        end
                    end
                    default: st <= S_PLL_RST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_clk_supervisor.sv
// tb/tb_tx_clk_supervisor.sv - directed self-checking bench for tx_clk_supervisor
module tb_tx_clk_supervisor;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic [1:0] ch_en;
    logic       lol_clr;
    logic       pll_rst;
    logic [1:0] ch_rst;
    logic       clk_ok;
    logic [1:0] state;
    logic [1:0] lol_count;
    logic [1:0] retry_count;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 refclk = ~refclk;

    tx_clk_supervisor #(
        .NUM_CH(2), .SYNC_STAGES(2), .PLL_RST_CYC(4), .LOCK_STABLE_CYC(16),
        .LOCK_TIMEOUT_CYC(64), .CH_STAGGER_CYC(8), .CNT_W(2)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .ch_en(ch_en),
        .lol_clr(lol_clr), .pll_rst(pll_rst), .ch_rst(ch_rst), .clk_ok(clk_ok),
        .state(state), .lol_count(lol_count), .retry_count(retry_count),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (state != 2'd3 && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, 32'(state), 32'd3);
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0; ch_en = 2'b11; lol_clr = 1'b0;
        tick(3);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_ch_rst", 32'(ch_rst), 32'd3);
        check("rst_clk_ok", 32'(clk_ok), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_lol", 32'(lol_count), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);

        rst = 1'b0;
        tick(3);
        check("pll_rst_hold3", 32'(pll_rst), 32'd1);
        tick(1);
        check("pll_rst_fall4", 32'(pll_rst), 32'd0);
        check("wait_state", 32'(state), 32'd1);

        // 10 cycles high, 1 low, then high: qualification restarts from the re-raise
        pll_locked = 1'b1;
        tick(10);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(17);
        check("glitch_no_rel_ch", 32'(ch_rst), 32'd3);
        check("glitch_no_rel_st", 32'(state), 32'd1);
        tick(1);
        check("rel_ch0", 32'(ch_rst), 32'd2);
        check("rel_state", 32'(state), 32'd2);
        check("glitch_lol", 32'(lol_count), 32'd0);
        tick(7);
        check("rel_ch1_hold", 32'(ch_rst), 32'd2);
        tick(1);
        check("rel_ch1", 32'(ch_rst), 32'd0);
        check("rel_clk_ok0", 32'(clk_ok), 32'd0);
        tick(1);
        check("run_clk_ok", 32'(clk_ok), 32'd1);
        check("run_state", 32'(state), 32'd3);

        ch_en = 2'b01;
        tick(1);
        check("run_ch1_off", 32'(ch_rst), 32'd2);
        ch_en = 2'b11;
        tick(1);
        check("run_ch1_on", 32'(ch_rst), 32'd0);

        // one-cycle lock drop in RUN, then restart with channel 0 disabled
        ch_en = 2'b10;
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("lol_sync_lat", 32'(state), 32'd3);
        tick(1);
        check("lol_ch_rst", 32'(ch_rst), 32'd3);
        check("lol_clk_ok", 32'(clk_ok), 32'd0);
        check("lol_cnt1", 32'(lol_count), 32'd1);
        check("lol_state", 32'(state), 32'd0);
        check("lol_pll_rst", 32'(pll_rst), 32'd1);
        tick(4);
        check("re_wait", 32'(state), 32'd1);
        check("re_pll_rst0", 32'(pll_rst), 32'd0);
        tick(15);
        check("re_wait_hold", 32'(state), 32'd1);
        tick(1);
        check("re_release", 32'(state), 32'd2);
        check("re_ch0_masked", 32'(ch_rst), 32'd3);
        tick(8);
        check("re_ch1", 32'(ch_rst), 32'd1);
        tick(1);
        check("re_run", 32'(state), 32'd3);
        check("re_run_ch", 32'(ch_rst), 32'd1);
        ch_en = 2'b11;
        tick(1);
        check("re_ch0_enable", 32'(ch_rst), 32'd0);

        // lock lost for good: timeout retries every 4+64 cycles
        pll_locked = 1'b0;
        tick(3);
        check("lol_cnt2", 32'(lol_count), 32'd2);
        tick(4);
        check("to_wait", 32'(pll_rst), 32'd0);
        tick(63);
        check("to_not_yet", 32'(retry_count), 32'd0);
        check("to_not_yet_st", 32'(state), 32'd1);
        tick(1);
        check("to1_pll_rst", 32'(pll_rst), 32'd1);
        check("to1_retry", 32'(retry_count), 32'd1);
        check("to1_terr", 32'(timeout_err), 32'd1);
        check("to1_state", 32'(state), 32'd0);
        tick(68);
        check("to2_retry", 32'(retry_count), 32'd2);
        check("to2_pll_rst", 32'(pll_rst), 32'd1);
        tick(68);
        check("to3_retry", 32'(retry_count), 32'd3);
        tick(68);
        check("to4_retry_sat", 32'(retry_count), 32'd3);
        check("to4_pll_rst", 32'(pll_rst), 32'd1);

        lol_clr = 1'b1;
        tick(1);
        lol_clr = 1'b0;
        check("clr_lol", 32'(lol_count), 32'd0);
        check("clr_retry", 32'(retry_count), 32'd0);
        check("clr_terr", 32'(timeout_err), 32'd0);
        tick(66);
        lol_clr = 1'b1;
        tick(1);
        lol_clr = 1'b0;
        check("clr_to_retry", 32'(retry_count), 32'd1);
        check("clr_to_terr", 32'(timeout_err), 32'd1);
        check("clr_to_pll_rst", 32'(pll_rst), 32'd1);

        // five loss-of-lock events saturate the 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            pll_locked = 1'b1;
            wait_run($sformatf("sat_run%0d", k));
            pll_locked = 1'b0;
            tick(3);
            check($sformatf("sat_lol%0d", k), 32'(lol_count), (k < 3) ? 32'(k) : 32'd3);
        end
        pll_locked = 1'b1;
        wait_run("sat_run6");
        pll_locked = 1'b0;
        tick(2);
        lol_clr = 1'b1;
        tick(1);
        lol_clr = 1'b0;
        check("clr_lol_evt", 32'(lol_count), 32'd1);
        check("clr_lol_state", 32'(state), 32'd0);

        pll_locked = 1'b1;
        wait_run("mid_run");
        rst = 1'b1;
        tick(1);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_ch", 32'(ch_rst), 32'd3);
        check("mid_rst_clk_ok", 32'(clk_ok), 32'd0);
        check("mid_rst_pll", 32'(pll_rst), 32'd1);
        check("mid_rst_lol", 32'(lol_count), 32'd0);
        check("mid_rst_retry", 32'(retry_count), 32'd0);
        check("mid_rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
